// File: rtl/vga_raster_scanner.sv
// VGA timing generator and pixel-fetch sequencer: raster counters issue fetch addresses,
// and sync/blank flags ride a delay line so they land on the pins together with the returned colour.
module vga_raster_scanner #(
   parameter int H_ACTIVE      = 640,
   parameter int H_FRONT       = 16,
   parameter int H_SYNC        = 96,
   parameter int H_BACK        = 48,
   parameter int V_ACTIVE      = 480,
   parameter int V_FRONT       = 10,
   parameter int V_SYNC        = 2,
   parameter int V_BACK        = 33,
   parameter int HS_POL        = 0,
   parameter int VS_POL        = 0,
   parameter int COLOR_BITS    = 4,
   parameter int FETCH_LATENCY = 2,
   localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
   localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
   input  logic                    pixel_clock,
   input  logic                    reset,
   output logic                    fetch_req,
   output logic [XW-1:0]           fetch_x,
   output logic [YW-1:0]           fetch_y,
   input  logic [3*COLOR_BITS-1:0] pix_data,
   output logic                    hsync,
   output logic                    vsync,
   output logic [COLOR_BITS-1:0]   RED,
   output logic [COLOR_BITS-1:0]   GREEN,
   output logic [COLOR_BITS-1:0]   BLUE,
   output logic                    video_on,
   output logic                    frame_start,
   output logic                    line_start
);

   localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int HCW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int VCW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
   localparam int HS_START = H_ACTIVE + H_FRONT;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FRONT;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam logic HS_ON  = 1'(HS_POL);
   localparam logic VS_ON  = 1'(VS_POL);

   typedef struct packed {
      logic active;
      logic hs_act;
      logic vs_act;
      logic sof;
      logic sol;
   } flags_t;

   logic [HCW-1:0] h_cnt_q, h_cnt_d;
   logic [VCW-1:0] v_cnt_q, v_cnt_d;
   flags_t         st0;
   flags_t         st_dly;

   always_comb begin
      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (int'(h_cnt_q) == H_TOTAL - 1) begin
         h_cnt_d = '0;
         v_cnt_d = (int'(v_cnt_q) == V_TOTAL - 1) ? '0 : v_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // vs_act depends only on v_cnt, so it switches together with the h_cnt wrap
   always_comb begin
      st0        = '0;
      st0.active = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
      st0.hs_act = (int'(h_cnt_q) >= HS_START) && (int'(h_cnt_q) < HS_END);
      st0.vs_act = (int'(v_cnt_q) >= VS_START) && (int'(v_cnt_q) < VS_END);
      st0.sof    = (h_cnt_q == '0) && (v_cnt_q == '0);
      st0.sol    = (h_cnt_q == '0) && (int'(v_cnt_q) < V_ACTIVE);
   end

   assign fetch_req = st0.active;
   assign fetch_x   = st0.active ? h_cnt_q[XW-1:0] : '0;
   assign fetch_y   = st0.active ? v_cnt_q[YW-1:0] : '0;

   generate
      if (FETCH_LATENCY > 0) begin : g_dly
         flags_t dly_q [FETCH_LATENCY];
         flags_t dly_d [FETCH_LATENCY];

         always_comb begin
            dly_d[0] = st0;
            for (int i = 1; i < FETCH_LATENCY; i++) dly_d[i] = dly_q[i-1];
         end

         always_ff @(posedge pixel_clock) begin
            for (int i = 0; i < FETCH_LATENCY; i++) begin
               if (reset) dly_q[i] <= '0;
               else       dly_q[i] <= dly_d[i];
            end
         end

         assign st_dly = dly_q[FETCH_LATENCY-1];
      end else begin : g_nodly
         assign st_dly = st0;
      end
   endgenerate

   logic                  hsync_q, hsync_d;
   logic                  vsync_q, vsync_d;
   logic                  video_on_q, video_on_d;
   logic                  frame_start_q, frame_start_d;
   logic                  line_start_q, line_start_d;
   logic [COLOR_BITS-1:0] red_q, red_d;
   logic [COLOR_BITS-1:0] green_q, green_d;
   logic [COLOR_BITS-1:0] blue_q, blue_d;

   // pix_data is only looked at while the delayed active flag says it belongs to a visible pixel
   always_comb begin
      hsync_d       = st_dly.hs_act ? HS_ON : ~HS_ON;
      vsync_d       = st_dly.vs_act ? VS_ON : ~VS_ON;
      video_on_d    = st_dly.active;
      frame_start_d = st_dly.sof;
      line_start_d  = st_dly.sol;
      red_d         = '0;
      green_d       = '0;
      blue_d        = '0;
      if (st_dly.active) begin
         red_d   = pix_data[3*COLOR_BITS-1 -: COLOR_BITS];
         green_d = pix_data[2*COLOR_BITS-1 -: COLOR_BITS];
         blue_d  = pix_data[COLOR_BITS-1:0];
      end
   end

   always_ff @(posedge pixel_clock) begin
      if (reset) begin
         hsync_q       <= ~HS_ON;
         vsync_q       <= ~VS_ON;
         video_on_q    <= 1'b0;
         frame_start_q <= 1'b0;
         line_start_q  <= 1'b0;
         red_q         <= '0;
         green_q       <= '0;
         blue_q        <= '0;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         frame_start_q <= frame_start_d;
         line_start_q  <= line_start_d;
         red_q         <= red_d;
         green_q       <= green_d;
         blue_q        <= blue_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign frame_start = frame_start_q;
   assign line_start  = line_start_q;
   assign RED         = red_q;
   assign GREEN       = green_q;
   assign BLUE        = blue_q;

endmodule

// File: tb/tb_vga_raster_scanner.sv
// Bench for vga_raster_scanner: three instances (default timing, short-frame, small variant) checked
// every cycle against a raster-position model, plus hand-computed timing and pixel checks.
module tb_vga_raster_scanner;

   typedef struct packed {
      int ha, hf, hsw, hb, va, vf, vsw, vb, hpol, vpol, fl;
   } cfg_t;

   typedef struct packed {
      logic       req;
      logic [9:0] fx;
      logic [9:0] fy;
      logic       hs;
      logic       vs;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       von;
      logic       fs;
      logic       ls;
   } obs_t;

   logic        clk = 1'b0;
   logic [2:0]  rst = 3'b111;
   int          c [3];
   logic [2:0]  valid = 3'b000;
   int          vectors = 0;
   int          miscompares = 0;
   logic [23:0] pix_val [3];
   logic [20:0] hist [3][8];
   obs_t        obs [3];

   always #5 clk = ~clk;

   // instance 0: default timing
   logic d_req, d_hs, d_vs, d_von, d_fs, d_ls;
   logic [9:0]  d_fx;
   logic [8:0]  d_fy;
   logic [11:0] d_pix;
   logic [3:0]  d_r, d_g, d_b;
   // instance 1: default horizontal, short frame
   logic v_req, v_hs, v_vs, v_von, v_fs, v_ls;
   logic [9:0]  v_fx;
   logic [3:0]  v_fy;
   logic [11:0] v_pix;
   logic [3:0]  v_r, v_g, v_b;
   // instance 2: tiny raster, zero latency, positive syncs, 8-bit colour
   logic s_req, s_hs, s_vs, s_von, s_fs, s_ls;
   logic [2:0]  s_fx;
   logic [1:0]  s_fy;
   logic [23:0] s_pix;
   logic [7:0]  s_r, s_g, s_b;

   vga_raster_scanner u_def (
      .pixel_clock(clk), .reset(rst[0]), .fetch_req(d_req), .fetch_x(d_fx), .fetch_y(d_fy),
      .pix_data(d_pix), .hsync(d_hs), .vsync(d_vs), .RED(d_r), .GREEN(d_g), .BLUE(d_b),
      .video_on(d_von), .frame_start(d_fs), .line_start(d_ls));

   vga_raster_scanner #(.V_ACTIVE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) u_vrt (
      .pixel_clock(clk), .reset(rst[1]), .fetch_req(v_req), .fetch_x(v_fx), .fetch_y(v_fy),
      .pix_data(v_pix), .hsync(v_hs), .vsync(v_vs), .RED(v_r), .GREEN(v_g), .BLUE(v_b),
      .video_on(v_von), .frame_start(v_fs), .line_start(v_ls));

   vga_raster_scanner #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2), .V_ACTIVE(4), .V_FRONT(1),
      .V_SYNC(1), .V_BACK(1), .HS_POL(1), .VS_POL(1), .COLOR_BITS(8), .FETCH_LATENCY(0)) u_var (
      .pixel_clock(clk), .reset(rst[2]), .fetch_req(s_req), .fetch_x(s_fx), .fetch_y(s_fy),
      .pix_data(s_pix), .hsync(s_hs), .vsync(s_vs), .RED(s_r), .GREEN(s_g), .BLUE(s_b),
      .video_on(s_von), .frame_start(s_fs), .line_start(s_ls));

   assign obs[0] = {d_req, d_fx, 10'(d_fy), d_hs, d_vs, 8'(d_r), 8'(d_g), 8'(d_b), d_von, d_fs, d_ls};
   assign obs[1] = {v_req, v_fx, 10'(v_fy), v_hs, v_vs, 8'(v_r), 8'(v_g), 8'(v_b), v_von, v_fs, v_ls};
   assign obs[2] = {s_req, 10'(s_fx), 10'(s_fy), s_hs, s_vs, s_r, s_g, s_b, s_von, s_fs, s_ls};

   assign d_pix = {pix_val[0][19:16], pix_val[0][11:8], pix_val[0][3:0]};
   assign v_pix = {pix_val[1][19:16], pix_val[1][11:8], pix_val[1][3:0]};
   assign s_pix = pix_val[2];

   function automatic cfg_t cfg(int i);
      case (i)
         0:       return '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2};
         1:       return '{640, 16, 96, 48, 12, 2, 2, 3, 0, 0, 2};
         default: return '{8, 2, 2, 2, 4, 1, 1, 1, 1, 1, 0};
      endcase
   endfunction

   // colour the pixel source returns for a given address, as {R,G,B} in 8-bit fields
   function automatic logic [23:0] src(int i, int x, int y);
      if (i == 2) return {8'(x * 29) ^ 8'hC3, 8'(y * 53) ^ 8'h3C, 8'((x + y) * 7) ^ 8'hA5};
      return {8'(x & 15), 8'(y & 15), 8'h0A};
   endfunction

   // pins at raster position cyc (cycles since counters sat at (0,0))
   function automatic obs_t model(int i, int cyc);
      cfg_t k;
      int ht, vt, x, y, p;
      logic [23:0] s;
      obs_t o;
      k  = cfg(i);
      ht = k.ha + k.hf + k.hsw + k.hb;
      vt = k.va + k.vf + k.vsw + k.vb;
      o  = '0;
      x  = cyc % ht;
      y  = (cyc / ht) % vt;
      if (x < k.ha && y < k.va) begin
         o.req = 1'b1;
         o.fx  = 10'(x);
         o.fy  = 10'(y);
      end
      o.hs = ~k.hpol[0];
      o.vs = ~k.vpol[0];
      p = cyc - k.fl - 1;
      if (p >= 0) begin
         x = p % ht;
         y = (p / ht) % vt;
         if (x >= k.ha + k.hf && x < k.ha + k.hf + k.hsw) o.hs = k.hpol[0];
         if (y >= k.va + k.vf && y < k.va + k.vf + k.vsw) o.vs = k.vpol[0];
         o.fs = (x == 0 && y == 0);
         o.ls = (x == 0 && y < k.va);
         if (x < k.ha && y < k.va) begin
            s     = src(i, x, y);
            o.von = 1'b1;
            o.r   = s[23:16];
            o.g   = s[15:8];
            o.b   = s[7:0];
         end
      end
      return o;
   endfunction

   function automatic logic [23:0] drive_pix(int i, logic r, logic [20:0] cur, logic [20:0] old);
      logic [20:0] e;
      e = (cfg(i).fl == 0) ? cur : old;
      if (r || !e[20]) return '1;
      return src(i, int'(e[19:10]), int'(e[9:0]));
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic goto(input int i, input int target);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (c[i] != target && n < 60000);
      if (c[i] != target) chk("goto_timeout", c[i], target);
   endtask

   initial forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         c[i] = rst[i] ? 0 : c[i] + 1;
         valid[i] = valid[i] | rst[i];
      end
   end

   // pixel source: answers each fetch FETCH_LATENCY clocks later, all-ones when nothing was fetched
   initial begin
      for (int i = 0; i < 3; i++) begin
         pix_val[i] = '1;
         for (int j = 0; j < 8; j++) hist[i][j] = '0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            pix_val[i] = drive_pix(i, rst[i], {obs[i].req, obs[i].fx, obs[i].fy},
                                   hist[i][(cfg(i).fl == 0) ? 0 : cfg(i).fl - 1]);
            for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = {obs[i].req, obs[i].fx, obs[i].fy};
         end
      end
   end

   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         if (valid[i]) begin
            obs_t e;
            e = model(i, c[i]);
            vectors++;
            if (obs[i] !== e) begin
               miscompares++;
               $display("FAIL model inst%0d c=%0d: got %h, expected %h", i, c[i], obs[i], e);
            end
         end
      end
   end

   initial begin
      int lows, vons, highs_h, highs_v, f0, f1, r0, fsn, lsn, fs0, fs1, target, n;
      logic prev;

      repeat (5) begin
         @(negedge clk);
         chk("rst_pins", int'({d_hs, d_vs, d_von, d_fs, d_ls, d_r, d_g, d_b}), 32'h18000);
         chk("rst_fetch", int'({d_req, d_fx, d_fy}), 32'h80000);
      end
      @(posedge clk);
      #1 rst = 3'b000;

      goto(0, 1);
      chk("var_first_px", int'({s_hs, s_vs, s_von, s_fs, s_ls, s_r, s_g, s_b}), 32'h07C33CA5);
      chk("def_not_yet", int'({d_von, d_fs}), 0);
      goto(0, 3);
      chk("def_first_px", int'({d_von, d_fs, d_ls, d_r, d_g, d_b}), 32'h700A);
      chk("def_fetch_c3", int'({d_req, d_fx, d_fy}), 32'h80600);
      goto(0, 50);
      chk("var_px_7_3", int'({s_hs, s_vs, s_von, s_fs, s_ls, s_r, s_g, s_b}), 32'h0408A3E3);

      highs_h = 0;
      highs_v = 0;
      for (int k = 0; k < 98; k++) begin
         @(negedge clk);
         if (s_hs) highs_h++;
         if (s_vs) highs_v++;
      end
      chk("var_hs_high", highs_h, 14);
      chk("var_vs_high", highs_v, 14);

      goto(0, 2408);
      chk("def_px_5_3", int'({d_von, d_fs, d_ls, d_r, d_g, d_b}), 32'h453A);

      lows = 0; vons = 0; f0 = -1; f1 = -1; r0 = -1; prev = d_hs;
      for (int k = 0; k < 2400; k++) begin
         @(negedge clk);
         if (!d_hs) lows++;
         if (d_von) vons++;
         if (prev && !d_hs) begin
            if (f0 < 0) f0 = c[0];
            else if (f1 < 0) f1 = c[0];
         end
         if (!prev && d_hs && f0 >= 0 && r0 < 0) r0 = c[0];
         prev = d_hs;
      end
      chk("hs_low_clocks", lows, 288);
      chk("von_clocks", vons, 1920);
      chk("hs_first_low", f0 % 800, 659);
      chk("hs_period", f1 - f0, 800);
      chk("hs_width", r0 - f0, 96);

      lows = 0; fsn = 0; lsn = 0; fs0 = -1; fs1 = -1; f0 = -1; r0 = -1; prev = v_vs;
      for (int k = 0; k < 30400; k++) begin
         @(negedge clk);
         if (!v_vs) lows++;
         if (v_ls) lsn++;
         if (v_fs) begin
            fsn++;
            if (fs0 < 0) fs0 = c[1];
            else if (fs1 < 0) fs1 = c[1];
         end
         if (prev && !v_vs && f0 < 0) f0 = c[1];
         if (!prev && v_vs && f0 >= 0 && r0 < 0) r0 = c[1];
         prev = v_vs;
      end
      chk("vs_low_clocks", lows, 3200);
      chk("fs_count", fsn, 2);
      chk("fs_period", fs1 - fs0, 15200);
      chk("ls_count", lsn, 24);
      chk("vs_first_low", f0 % 15200, 11203);
      chk("vs_width", r0 - f0, 1600);

      target = ((c[0] / 800) + 1) * 800 + 300;
      n = 0;
      do begin
         @(posedge clk);
         #1 n++;
      end while (c[0] != target && n < 2000);
      chk("midrst_reach", c[0], target);
      rst[0] = 1'b1;
      @(posedge clk);
      #1 rst[0] = 1'b0;
      chk("midrst_pins", int'({d_hs, d_vs, d_von, d_fs, d_ls, d_r, d_g, d_b}), 32'h18000);
      chk("midrst_fetch", int'({d_req, d_fx, d_fy}), 32'h80000);
      goto(0, 1);
      chk("midrst_fs_c1", int'(d_fs), 0);
      goto(0, 2);
      chk("midrst_fs_c2", int'(d_fs), 0);
      goto(0, 3);
      chk("midrst_fs_c3", int'({d_fs, d_von}), 3);

      repeat (500) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
